// File: rtl/demux_1_to_4_deser.sv
// -----------------------------------------------------------------------------
// demux_1_to_4_deser
//
// Purpose:
//   1-to-4 serial-to-parallel deserializer with valid/ready handshakes on both
//   sides. Serial bits are steered into a 4-bit capture register slot by slot.
//   When the fourth bit of a word is accepted, the completed word moves into
//   the output register A. Collection of the next word continues while A is
//   still waiting to be consumed, so the capture register and A together act
//   as a double buffer.
//
// Parameters:
//   LSB_FIRST  1: the first bit of a word lands in A[0].
//              0: the first bit of a word lands in A[3].
//
// Ports:
//   clk        in   single clock, rising-edge active
//   reset      in   synchronous active-high reset
//   B          in   serial data bit
//   B_valid    in   B holds a bit to transfer
//   B_ready    out  block can accept B this cycle (combinational)
//   clear      in   synchronous abort of the partially collected word
//   A          out  assembled 4-bit parallel word
//   A_valid    out  A holds an unconsumed word
//   out_ready  in   consumer takes A this cycle when A_valid=1
//   control    out  A bit index the next accepted B will be written to
// -----------------------------------------------------------------------------
module demux_1_to_4_deser #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       B,
    input  logic       B_valid,
    output logic       B_ready,
    input  logic       clear,
    output logic [3:0] A,
    output logic       A_valid,
    input  logic       out_ready,
    output logic [1:0] control
);

    logic [1:0] r_ctr;
    logic [3:0] r_cap;
    logic [3:0] r_a;
    logic       r_a_valid;

    logic [1:0] w_control;
    logic [3:0] w_word;
    logic       w_ready;
    logic       w_accept;
    logic       w_complete;

    // Slot index: counts up for LSB-first, down from 3 for MSB-first.
    assign w_control = (LSB_FIRST != 0) ? r_ctr : (2'd3 - r_ctr);

    // Stall only when the last slot would complete a word while A is still
    // occupied and not being drained this cycle. clear is deliberately not
    // part of this equation.
    assign w_ready    = !((r_ctr == 2'd3) && r_a_valid && !out_ready);
    assign w_accept   = B_valid && w_ready;
    assign w_complete = w_accept && (r_ctr == 2'd3) && !clear;

    // Capture register with the incoming bit merged into its slot. This is both
    // the next cap value on accept and the completed word on the fourth accept.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign w_word[gi] = (w_control == 2'(gi)) ? B : r_cap[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctr     <= 2'd0;
            r_cap     <= 4'd0;
            r_a       <= 4'd0;
            r_a_valid <= 1'b0;
        end else begin
            // Capture side: clear wins over any bit accepted this cycle.
            if (clear) begin
                r_ctr <= 2'd0;
                r_cap <= 4'd0;
            end else if (w_accept) begin
                r_ctr <= r_ctr + 2'd1;
                r_cap <= w_word;
            end

            // Output side: a completing word overrides the drain so a word
            // consumed in the same cycle is replaced without a bubble.
            if (w_complete) begin
                r_a       <= w_word;
                r_a_valid <= 1'b1;
            end else if (r_a_valid && out_ready) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign B_ready = w_ready;
    assign A       = r_a;
    assign A_valid = r_a_valid;
    assign control = w_control;

endmodule

// File: tb/tb_demux_1_to_4_deser.sv
// -----------------------------------------------------------------------------
// tb_demux_1_to_4_deser
//
// Two instances (LSB-first and MSB-first) share all inputs. A driver applies
// stimulus on the falling edge and keeps a word-level reference model (a queue
// of collected bits plus the held output word). Completed words are pushed to
// scoreboard queues; a separate monitor pops and compares on every output
// handshake.
// -----------------------------------------------------------------------------
module tb_demux_1_to_4_deser;

    logic       clk;
    logic       reset;
    logic       B;
    logic       B_valid;
    logic       clear;
    logic       out_ready;

    logic       br_l, br_m;
    logic [3:0] a_l, a_m;
    logic       av_l, av_m;
    logic [1:0] ctl_l, ctl_m;

    demux_1_to_4_deser #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .B(B), .B_valid(B_valid), .B_ready(br_l),
        .clear(clear), .A(a_l), .A_valid(av_l), .out_ready(out_ready),
        .control(ctl_l)
    );

    demux_1_to_4_deser #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .B(B), .B_valid(B_valid), .B_ready(br_m),
        .clear(clear), .A(a_m), .A_valid(av_m), .out_ready(out_ready),
        .control(ctl_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks    = 0;
    int failures  = 0;
    int words_exp = 0;
    int words_got = 0;
    int completed = 0;

    // Reference model state
    bit         part[$];
    logic [3:0] q_l[$];
    logic [3:0] q_m[$];
    bit         held_valid = 1'b0;
    logic [3:0] held_l = 4'd0;
    logic [3:0] held_m = 4'd0;
    bit         known = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model to the state after the coming rising edge.
    task automatic step(input logic b_i, input logic bv_i, input logic clr_i,
                        input logic ordy_i, input logic rst_i);
        logic       exp_ready;
        logic       consume;
        logic       done;
        logic [3:0] wl;
        logic [3:0] wm;
        logic [1:0] slot;
        @(negedge clk);
        B = b_i; B_valid = bv_i; clear = clr_i; out_ready = ordy_i; reset = rst_i;
        #1;
        exp_ready = !(part.size() == 3 && held_valid && !ordy_i);
        if (known) begin
            slot = 2'(part.size());
            chk("control_lsb", {2'b00, ctl_l}, {2'b00, slot});
            chk("control_msb", {2'b00, ctl_m}, {2'b00, 2'd3 - slot});
            chk("b_ready_lsb", {3'b000, br_l}, {3'b000, exp_ready});
            chk("b_ready_msb", {3'b000, br_m}, {3'b000, exp_ready});
            chk("a_valid_lsb", {3'b000, av_l}, {3'b000, held_valid});
            chk("a_valid_msb", {3'b000, av_m}, {3'b000, held_valid});
            chk("a_lsb", a_l, held_l);
            chk("a_msb", a_m, held_m);
        end
        if (rst_i) begin
            part.delete();
            words_exp -= q_l.size();
            q_l.delete();
            q_m.delete();
            held_valid = 1'b0;
            held_l = 4'd0;
            held_m = 4'd0;
            known = 1'b1;
        end else begin
            consume = held_valid && ordy_i;
            done = 1'b0;
            wl = 4'd0;
            wm = 4'd0;
            if (clr_i) begin
                part.delete();
            end else if (bv_i && exp_ready) begin
                part.push_back(b_i);
                if (part.size() == 4) begin
                    for (int i = 0; i < 4; i++) begin
                        wl[i]     = part[i];
                        wm[3 - i] = part[i];
                    end
                    q_l.push_back(wl);
                    q_m.push_back(wm);
                    part.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                held_valid = 1'b1;
                held_l = wl;
                held_m = wm;
                words_exp++;
                completed++;
            end else if (consume) begin
                held_valid = 1'b0;
            end
        end
    endtask

    // Monitor: a handshake at the coming edge consumes the oldest expected word.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && av_l === 1'b1 && out_ready === 1'b1) begin
                if (q_l.size() == 0 || q_m.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_word actual=%b required=none", a_l);
                end else begin
                    e = q_l.pop_front();
                    chk("mon_word_lsb", a_l, e);
                    e = q_m.pop_front();
                    chk("mon_word_msb", a_m, e);
                    words_got++;
                end
            end
        end
    end

    initial begin
        int target;
        int cyc;
        logic [3:0] bits;
        B = 0; B_valid = 0; clear = 0; out_ready = 0; reset = 1;

        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("reset_a", a_l, 4'b0000);
        chk("reset_ctl_msb", {2'b00, ctl_m}, 4'd3);

        // Bits 1,0,1,1 with out_ready held high
        bits = 4'b1101;
        for (int i = 0; i < 4; i++) step(bits[i], 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("dir_lsb_word", a_l, 4'b1101);
        chk("dir_msb_word", a_m, 4'b1011);
        step(0, 0, 0, 1, 0);
        chk("dir_valid_one_cycle", {3'b000, av_l}, 4'd0);

        // Back-pressure: 1111 then 0000 with out_ready low
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("bp_ready_low", {3'b000, br_l}, 4'd0);
        chk("bp_hold_word", a_l, 4'b1111);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("bp_new_word", a_l, 4'b0000);
        chk("bp_valid_kept", {3'b000, av_l}, 4'd1);
        step(0, 0, 0, 1, 0);

        // Clear aborts a partial word
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        bits = 4'b0110;
        for (int i = 0; i < 4; i++) step(bits[i], 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("clr_word_lsb", a_l, 4'b0110);
        chk("clr_word_msb", a_m, 4'b0110);
        step(0, 0, 0, 1, 0);

        // Reset while a word is held and two bits are collected
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("rst_a", a_l, 4'b0000);
        chk("rst_a_valid", {3'b000, av_l}, 4'd0);
        chk("rst_control", {2'b00, ctl_l}, 4'd0);
        chk("rst_b_ready", {3'b000, br_l}, 4'd1);

        // Random stream of 1000 words
        target = completed + 1000;
        cyc = 0;
        while (completed < target && cyc < 40000) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                 1'b0, ($urandom_range(0, 9) < 6), 1'b0);
            cyc++;
        end
        chk("rnd_completed", {3'b000, (completed >= target)}, 4'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        checks++;
        if (words_got != words_exp || q_l.size() != 0) begin
            failures++;
            $display("FAIL word_count actual=%0d required=%0d pending=%0d",
                     words_got, words_exp, q_l.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
